// File: rtl/mult_useq_pkg.sv
// Shared definitions for the Robertson multiplier microprogram sequencer:
// microword field positions, branch condition codes and sequencer states.
package mult_useq_pkg;

    // Microword layout: {cond[2:0], next[4:0], ctrl[14:0]}
    localparam int UWORD_W = 23;
    localparam int UADDR_W = 5;
    localparam int CTRL_W  = 15;
    localparam int COND_HI = 22;
    localparam int COND_LO = 20;
    localparam int NEXT_HI = 19;
    localparam int NEXT_LO = 15;

    // Branch field encodings; the three reserved codes act as an unconditional jump
    typedef enum logic [2:0] {
        COND_JMP = 3'b000,
        COND_C0  = 3'b001,
        COND_C1  = 3'b010,
        COND_C2  = 3'b011,
        COND_CNT = 3'b100,
        COND_R5  = 3'b101,
        COND_R6  = 3'b110,
        COND_R7  = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // True when the microword's branch to its next field is taken
    function automatic logic cond_taken(input cond_e c, input logic [2:0] cin,
                                        input logic cnt_nz);
        logic hit;
        case (c)
            COND_C0:  hit = cin[0];
            COND_C1:  hit = cin[1];
            COND_C2:  hit = cin[2];
            COND_CNT: hit = cnt_nz;
            default:  hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/mult_useq.sv
// Microprogram sequencer for the Robertson multiplier. Holds the micro-PC
// that addresses the external control ROM, resolves the branch field of the
// fetched word against datapath status and an iteration counter, and gates
// the control field onto the datapath only while a run is active.
module mult_useq
    import mult_useq_pkg::*;
#(
    parameter int ITER      = 8,
    parameter int HALT_ADDR = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2:0]           cond_in,
    input  logic [UWORD_W-1:0]   rom_data,
    output logic [UADDR_W-1:0]   rom_addr,
    output logic [CTRL_W-1:0]    ctrl,
    output logic                 busy,
    output logic                 done
);

    localparam int                 CNT_W    = (ITER < 1) ? 1 : $clog2(ITER + 1);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(ITER);
    localparam logic [UADDR_W-1:0] HALT_PC  = UADDR_W'(HALT_ADDR);

    state_e               state_q, state_d;
    logic [UADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;

    cond_e                uw_cond;
    logic [UADDR_W-1:0]   uw_next;
    logic [CTRL_W-1:0]    uw_ctrl;
    logic                 cnt_nz;
    logic                 at_halt;
    logic [UADDR_W-1:0]   pc_inc;
    logic [UADDR_W-1:0]   pc_branch;

    // Split the fetched microword and resolve the branch target for this cycle
    always_comb begin
        uw_cond   = cond_e'(rom_data[COND_HI:COND_LO]);
        uw_next   = rom_data[NEXT_HI:NEXT_LO];
        uw_ctrl   = rom_data[CTRL_W-1:0];
        cnt_nz    = (cnt_q != '0);
        at_halt   = (pc_q == HALT_PC);
        // Wrap from 31 to 0 is natural modulo arithmetic; microcode never uses it
        pc_inc    = pc_q + UADDR_W'(1);
        pc_branch = cond_taken(uw_cond, cond_in, cnt_nz) ? uw_next : pc_inc;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks the halt check, start is ignored mid-run
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (at_halt) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for micro-PC, iteration counter and the sticky done flag
    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pc_d   = '0;
                    cnt_d  = CNT_INIT;
                    done_d = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    pc_d = '0;
                end else begin
                    // The halt word still executes, so a counter test in it still counts
                    if (uw_cond == COND_CNT && cnt_nz) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (at_halt) begin
                        done_d = 1'b1;
                    end else begin
                        pc_d = pc_branch;
                    end
                end
            end
            default: begin
                pc_d = '0;
            end
        endcase
    end

    // Micro-PC, counter and done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Outputs; ctrl is gated combinationally so an abort silences the current word
    always_comb begin
        rom_addr = pc_q;
        busy     = (state_q == RUN);
        done     = done_q;
        ctrl     = ((state_q == RUN) && !abort) ? uw_ctrl : '0;
    end

endmodule

// File: tb/tb_mult_useq.sv
// Bench for mult_useq: a directed test ROM on an ITER=2 instance, and a
// production-style Robertson microprogram on an ITER=8 instance driven by a
// small datapath model supplying the multiplier LSB and sign.
module tb_mult_useq;
    import mult_useq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [2:0]  cond_a, cond_b = 3'b000;
    logic [22:0] rom_data_a, rom_data_b;
    logic [4:0]  addr_a, addr_b;
    logic [14:0] ctrl_a, ctrl_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [22:0] rom_a [0:31];
    logic [22:0] rom_b [0:31];

    assign rom_data_a = rom_a[addr_a];
    assign rom_data_b = rom_b[addr_b];

    mult_useq #(.ITER(8), .HALT_ADDR(17)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .cond_in(cond_a), .rom_data(rom_data_a), .rom_addr(addr_a),
        .ctrl(ctrl_a), .busy(busy_a), .done(done_a)
    );

    mult_useq #(.ITER(2), .HALT_ADDR(17)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .cond_in(cond_b), .rom_data(rom_data_b), .rom_addr(addr_b),
        .ctrl(ctrl_b), .busy(busy_b), .done(done_b)
    );

    // Datapath model for DUT A: ctrl bit0 loads the multiplier, bit4 shifts it right
    logic [7:0] mult_a = 8'h00;
    logic [7:0] q_a = 8'h00;
    logic       sgn_a = 1'b0;
    logic       ld_s = 1'b0, sh_s = 1'b0;

    always @(negedge clk) begin
        ld_s <= ctrl_a[0];
        sh_s <= ctrl_a[4];
    end

    always @(posedge clk) begin
        if (ld_s) begin
            q_a   <= mult_a;
            sgn_a <= mult_a[7];
        end else if (sh_s) begin
            q_a <= q_a >> 1;
        end
    end

    assign cond_a = {sgn_a, 1'b0, q_a[0]};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [22:0] uw(input logic [2:0] c, input logic [4:0] n,
                                       input logic [14:0] k);
        return {c, n, k};
    endfunction

    typedef struct {
        logic        st;
        logic [2:0]  cin;
        logic [4:0]  addr;
        logic [14:0] ctrl;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic st, input logic [2:0] cin, input logic [4:0] addr,
                        input logic [14:0] ctrl, input logic busy, input logic done);
        vec_t v;
        v.st = st; v.cin = cin; v.addr = addr; v.ctrl = ctrl; v.busy = busy; v.done = done;
        tbl.push_back(v);
    endtask

    // One production run on DUT A; called at a falling edge
    task automatic run_prod(input logic [7:0] m, input int exp_cyc, input int exp_add,
                            input int exp_sub);
        int cyc, adds, subs, guard;
        logic [4:0] last;
        logic early_done;
        cyc = 0; adds = 0; subs = 0; guard = 0; last = '0; early_done = 1'b0;
        mult_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        while (busy_a === 1'b1 && guard < 100) begin
            cyc++;
            if (ctrl_a[3])  adds++;
            if (ctrl_a[10]) subs++;
            if (done_a !== 1'b0) early_done = 1'b1;
            last = addr_a;
            @(negedge clk);
            guard++;
        end
        chk($sformatf("prod %0h cycles", m), 32'(cyc), 32'(exp_cyc));
        chk($sformatf("prod %0h adds", m), 32'(adds), 32'(exp_add));
        chk($sformatf("prod %0h subs", m), 32'(subs), 32'(exp_sub));
        chk($sformatf("prod %0h last pc", m), {27'd0, last}, 32'd17);
        chk($sformatf("prod %0h done", m), {31'd0, done_a}, 32'd1);
        chk($sformatf("prod %0h done early", m), {31'd0, early_done}, 32'd0);
        chk($sformatf("prod %0h ctrl after", m), {17'd0, ctrl_a}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        for (int i = 0; i < 32; i++) begin
            rom_a[i] = '0;
            rom_b[i] = '0;
        end
        // Directed ROM
        rom_b[0]  = uw(3'b000, 5'd1,  15'h0003);
        rom_b[1]  = uw(3'b000, 5'd2,  15'h000C);
        rom_b[2]  = uw(3'b111, 5'd4,  15'h0300);
        rom_b[4]  = uw(3'b010, 5'd6,  15'h0010);
        rom_b[5]  = uw(3'b000, 5'd11, 15'h0020);
        rom_b[6]  = uw(3'b000, 5'd11, 15'h0040);
        rom_b[11] = uw(3'b100, 5'd3,  15'h0080);
        rom_b[3]  = uw(3'b000, 5'd11, 15'h0100);
        rom_b[12] = uw(3'b101, 5'd17, 15'h0200);
        rom_b[17] = uw(3'b000, 5'd0,  15'h4000);
        // Production Robertson microprogram
        rom_a[0]  = uw(3'b000, 5'd1,  15'h0001);
        rom_a[1]  = uw(3'b000, 5'd2,  15'h0002);
        rom_a[2]  = uw(3'b001, 5'd4,  15'h1000);
        rom_a[3]  = uw(3'b000, 5'd5,  15'h0004);
        rom_a[4]  = uw(3'b000, 5'd5,  15'h0008);
        rom_a[5]  = uw(3'b000, 5'd6,  15'h0010);
        rom_a[6]  = uw(3'b100, 5'd2,  15'h0020);
        rom_a[7]  = uw(3'b011, 5'd14, 15'h0040);
        rom_a[8]  = uw(3'b000, 5'd9,  15'h0080);
        rom_a[9]  = uw(3'b000, 5'd10, 15'h0100);
        rom_a[10] = uw(3'b000, 5'd17, 15'h0200);
        rom_a[14] = uw(3'b000, 5'd15, 15'h0400);
        rom_a[15] = uw(3'b000, 5'd17, 15'h0800);
        rom_a[17] = uw(3'b000, 5'd17, 15'h4000);

        // Branch-taken run (cond_in[1]=1) then fall-through run (cond_in=0)
        for (int r = 0; r < 2; r++) begin
            logic [2:0] ci;
            ci = (r == 0) ? 3'b010 : 3'b000;
            addv(1'b1, ci, 5'd0,  15'h0003, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd1,  15'h000C, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd2,  15'h0300, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd4,  15'h0010, 1'b1, 1'b0);
            if (r == 0) addv(1'b0, ci, 5'd6, 15'h0040, 1'b1, 1'b0);
            else        addv(1'b0, ci, 5'd5, 15'h0020, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd11, 15'h0080, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd3,  15'h0100, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd11, 15'h0080, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd3,  15'h0100, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd11, 15'h0080, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd12, 15'h0200, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd17, 15'h4000, 1'b1, 1'b0);
            addv(1'b0, ci, 5'd17, 15'h0000, 1'b0, 1'b1);
            addv(1'b0, ci, 5'd17, 15'h0000, 1'b0, 1'b1);
        end

        // Reset state
        #12;
        chk("reset addr_b", {27'd0, addr_b}, 32'd0);
        chk("reset ctrl_b", {17'd0, ctrl_b}, 32'd0);
        chk("reset busy_b", {31'd0, busy_b}, 32'd0);
        chk("reset done_b", {31'd0, done_b}, 32'd0);
        chk("reset busy_a", {31'd0, busy_a}, 32'd0);
        chk("reset done_a", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle no start busy", {31'd0, busy_b}, 32'd0);
        chk("idle no start addr", {27'd0, addr_b}, 32'd0);

        // Table-driven directed runs on DUT B
        for (int i = 0; i < tbl.size(); i++) begin
            cond_b  = tbl[i].cin;
            start_b = tbl[i].st;
            @(negedge clk);
            chk($sformatf("tbl[%0d] addr", i), {27'd0, addr_b}, {27'd0, tbl[i].addr});
            chk($sformatf("tbl[%0d] ctrl", i), {17'd0, ctrl_b}, {17'd0, tbl[i].ctrl});
            chk($sformatf("tbl[%0d] busy", i), {31'd0, busy_b}, {31'd0, tbl[i].busy});
            chk($sformatf("tbl[%0d] done", i), {31'd0, done_b}, {31'd0, tbl[i].done});
        end
        start_b = 1'b0;

        // Asynchronous reset while in DONE clears done and the held PC
        #2 rst_n = 1'b0;
        #1;
        chk("rst in done: done", {31'd0, done_b}, 32'd0);
        chk("rst in done: addr", {27'd0, addr_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-run
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun addr before rst", {27'd0, addr_b}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun rst addr", {27'd0, addr_b}, 32'd0);
        chk("midrun rst ctrl", {17'd0, ctrl_b}, 32'd0);
        chk("midrun rst busy", {31'd0, busy_b}, 32'd0);
        chk("midrun rst done", {31'd0, done_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after rst stays idle busy", {31'd0, busy_b}, 32'd0);
        chk("after rst stays idle addr", {27'd0, addr_b}, 32'd0);

        // Production microprogram, 9 loop passes, sign correction path for negative
        run_prod(8'h5B, 43, 5, 0);
        run_prod(8'hA6, 42, 4, 1);
        run_prod(8'h00, 43, 0, 0);

        // Start held high in DONE restarts at PC 0 and is ignored while running
        mult_a  = 8'h35;
        start_a = 1'b1;
        @(negedge clk);
        chk("restart busy", {31'd0, busy_a}, 32'd1);
        chk("restart addr", {27'd0, addr_a}, 32'd0);
        chk("restart done", {31'd0, done_a}, 32'd0);
        guard = 0;
        while (addr_a !== 5'd9 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("reach pc 9", {27'd0, addr_a}, 32'd9);
        chk("pc 9 ctrl", {17'd0, ctrl_a}, 32'h0100);
        // Abort together with start at PC 9
        abort_a = 1'b1;
        #1;
        chk("abort ctrl gated", {17'd0, ctrl_a}, 32'd0);
        chk("abort busy same cycle", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        chk("abort busy", {31'd0, busy_a}, 32'd0);
        chk("abort addr", {27'd0, addr_a}, 32'd0);
        chk("abort done", {31'd0, done_a}, 32'd0);
        abort_a = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        chk("post abort idle busy", {31'd0, busy_a}, 32'd0);
        chk("post abort idle addr", {27'd0, addr_a}, 32'd0);
        chk("post abort ctrl", {17'd0, ctrl_a}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_useq.md
# mult_useq

Microprogram sequencer for the Robertson multiplier. Owns the 5-bit micro-PC and drives the address of the external 23-bit control ROM. It decodes the branch field of the fetched word against datapath status and an internal iteration counter, and gates the 15-bit control field onto the datapath. It also gives the top level a start/done handshake.

## Interface
Parameters:
- `ITER`, default 8: loop count loaded into the iteration counter on start (operand width).
- `HALT_ADDR`, default 17: micro-address whose execution ends a run.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: level-sampled request to begin a multiplication.
- `abort` input 1: synchronous abandon of the current run.
- `cond_in` input 3: datapath status bits, e.g. multiplier LSB/sign flags; sampled the cycle they are used.
- `rom_data` input 23: fetched microword; combinational from `rom_addr`.
- `rom_addr` output 5: registered micro-PC.
- `ctrl` output 15: datapath control strobes.
- `busy` output 1: a run is in progress.
- `done` output 1: the last run completed; held until the next start.

## Operation
- Microword fields: `[22:20]` cond, `[19:15]` next, `[14:0]` ctrl.
- Cond codes decide the next PC:
  - 000: PC←next.
  - 001 / 010 / 011: PC←next if `cond_in[0]` / `[1]` / `[2]` is 1; otherwise PC←PC+1.
  - 100: PC←next if cnt≠0, otherwise PC+1. The counter decrements in the same cycle when cnt≠0 and saturates at 0.
  - 101–111 are reserved and behave as 000.
- States:
  - IDLE: `busy`=0, `ctrl`=0. On `start`=1, go to RUN with PC←0, cnt←ITER, `done`←0.
  - RUN: `busy`=1, `ctrl`=`rom_data[14:0]`. Each cycle, PC←computed next.
    - If PC==HALT_ADDR this cycle, that word still executes with its ctrl driven. Next state is DONE; PC holds.
  - DONE: `busy`=0, `ctrl`=0, `done`=1.
    - `start`=1 behaves as in IDLE.
    - `start`=0 stays in DONE.
- `abort`=1 in RUN: go to IDLE, PC←0, `ctrl` forced 0 in that same cycle (combinational gate), `done` stays 0. `abort` has priority over the HALT check and over `start`.
- `start` in RUN is ignored.
- PC+1 from 31 wraps to 0. Microcode never relies on the wrap; it is defined only to avoid X.
- Reset values: state IDLE, PC=0, cnt=0, `rom_addr`=0, `ctrl`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled high at edge E0 means `busy`=1 and `rom_addr`=0 after E0. Word 0 ctrl is valid during the cycle E0→E1.
- One microword per cycle with no stalls. Run length in cycles equals the number of words executed, including HALT_ADDR.
- `done` rises on the edge after the HALT word's cycle, and `busy` falls on the same edge.
- `ctrl` is combinational from registered PC and ROM. It is settled within the cycle and must be registered or sampled by the datapath at the next edge.
- Reset asserted mid-run clears everything immediately (asynchronously). The first run after release requires `start`.

## Structure
- Package `mult_useq_pkg` holds:
  - field-position localparams (COND_HI/LO, NEXT_HI/LO, CTRL_W=15, UADDR_W=5, UWORD_W=23);
  - the cond-code enum;
  - the state enum {IDLE, RUN, DONE}.
- No sub-module. The ROM is instantiated beside the sequencer at the multiplier top level and connected through `rom_addr`/`rom_data`.
- Iteration counter width is $clog2(ITER+1).

## Test plan
- Reset: hold `rst_n`=0 mid-run, then release. Required: `rom_addr`=0, `ctrl`=0, `busy`=0, `done`=0, and no activity until `start`.
- Unconditional chain: ROM words 0→1→2 with cond 000 and ctrl 0x0003, 0x000C, 0x0300; pulse `start`. Required: `rom_addr` sequence 0,1,2 and `ctrl` 0x0003, 0x000C, 0x0300 in consecutive cycles.
- Status branch: word at 4 with cond 010 and next 6.
  - With `cond_in`=3'b010: the next `rom_addr` is 6.
  - With `cond_in`=3'b000: the next `rom_addr` is 5.
- Counter loop, ITER=2: word 11 with cond 100 and next 3.
  - Passes 1–2: branch to 3.
  - Pass 3, cnt=0: fall to 12.
- Full multiply with the production ROM, ITER=8, HALT_ADDR=17, `cond_in` from a model:
  - `done` rises exactly one cycle after PC=17 executes.
  - `start` held high in DONE restarts at PC 0.
- Abort at PC=9: `ctrl`=0 in that cycle, then IDLE with `rom_addr`=0 and `done`=0. A simultaneous `start` in that cycle is ignored.
